top_n3_computer_iobus_vga_ps2: RTL and testbench

Board-level I/O top for the N3 teaching computer. It receives PS/2 keyboard scan codes and keeps the last four bytes. It shows the latest byte on the LEDs and the code history on a 4-digit multiplexed 7-segment display. It also generates 640x480 VGA sync with a switch-selected colour.

---
 rtl/top_n3_computer_iobus_vga_ps2.sv | 190 +++++++++++++++++++
 tb/tb_top_n3_computer_iobus_vga_ps2.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_n3_computer_iobus_vga_ps2.sv
// N3 board I/O top: PS/2 scan-code receiver with a 4-byte history, LED and
// multiplexed 7-segment readout, and a 640x480 VGA sync/colour generator.
module top_n3_computer_iobus_vga_ps2 #(
    parameter int SCAN_BITS   = 19,
    parameter int PIX_DIV     = 4,
    parameter int PS2_TIMEOUT = 65535
) (
    input  logic       clk_100mhz,
    input  logic [4:0] BTN,
    input  logic [7:0] SW,
    input  logic       PS2_clk,
    input  logic       PS2_Data,
    output logic [7:0] LED,
    output logic [7:0] SEGMENT,
    output logic [3:0] AN_SEL,
    output logic [2:0] Red,
    output logic [2:0] Green,
    output logic [1:0] Blue,
    output logic       HSYNC,
    output logic       VSYNC
);
    localparam int TMO_W = (PS2_TIMEOUT > 1) ? $clog2(PS2_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PS2_TIMEOUT - 1);
    localparam int PIX_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_DIV - 1);

    logic w_rst;
    assign w_rst = BTN[3];

    // ---------------- PS/2 receiver ----------------
    logic [1:0]       r_c_sync, r_d_sync;
    logic             r_c_prev;
    logic [3:0]       r_bitcnt;
    logic [7:0]       r_shift;
    logic [TMO_W-1:0] r_tmo;
    logic [31:0]      r_hist;
    logic [7:0]       r_led;
    logic             w_fall, w_din, w_accept;

    // Sync flops reset low so a reset released with the PS/2 clock low never
    // fakes a falling edge.
    always_ff @(posedge clk_100mhz or posedge w_rst) begin
        if (w_rst) begin
            r_c_sync <= 2'b00;
            r_d_sync <= 2'b00;
            r_c_prev <= 1'b0;
        end else begin
            r_c_sync <= {r_c_sync[0], PS2_clk};
            r_d_sync <= {r_d_sync[0], PS2_Data};
            r_c_prev <= r_c_sync[1];
        end
    end

    assign w_fall   = r_c_prev & ~r_c_sync[1];
    assign w_din    = r_d_sync[1];
    assign w_accept = w_fall && (r_bitcnt == 4'd10) && w_din;

    always_ff @(posedge clk_100mhz or posedge w_rst) begin
        if (w_rst) begin
            r_bitcnt <= 4'd0;
            r_shift  <= 8'h00;
            r_tmo    <= '0;
        end else if (w_fall) begin
            r_tmo <= '0;
            if (r_bitcnt == 4'd0) begin
                if (!w_din) r_bitcnt <= 4'd1;
            end else if (r_bitcnt <= 4'd8) begin
                r_shift  <= {w_din, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 4'd1;
            end else if (r_bitcnt == 4'd9) begin
                r_bitcnt <= 4'd10;
            end else begin
                r_bitcnt <= 4'd0;
            end
        end else if (r_bitcnt != 4'd0) begin
            // A stalled frame is dropped so the next start bit realigns.
            if (r_tmo == TMO_LAST) begin
                r_bitcnt <= 4'd0;
                r_tmo    <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end else begin
            r_tmo <= '0;
        end
    end

    always_ff @(posedge clk_100mhz or posedge w_rst) begin
        if (w_rst) begin
            r_hist <= 32'h0;
            r_led  <= 8'h00;
        end else if (BTN[0]) begin
            r_hist <= 32'h0;
            r_led  <= 8'h00;
        end else if (w_accept) begin
            r_hist <= {r_hist[23:0], r_shift};
            r_led  <= r_shift;
        end
    end

    assign LED = r_led;

    // ---------------- 7-segment scan ----------------
    logic [SCAN_BITS-1:0] r_scan;
    logic [1:0]           w_digit;
    logic [15:0]          w_word;
    logic [3:0]           w_nib;
    logic [7:0]           w_seg;
    logic [7:0]           r_seg;
    logic [3:0]           r_an;

    assign w_digit = r_scan[SCAN_BITS-1 -: 2];
    assign w_word  = SW[0] ? r_hist[31:16] : r_hist[15:0];
    assign w_nib   = w_word[{w_digit, 2'b00} +: 4];

    always_comb begin
        w_seg = 8'hC0;
        case (w_nib)
            4'h0: w_seg = 8'hC0;  4'h1: w_seg = 8'hF9;
            4'h2: w_seg = 8'hA4;  4'h3: w_seg = 8'hB0;
            4'h4: w_seg = 8'h99;  4'h5: w_seg = 8'h92;
            4'h6: w_seg = 8'h82;  4'h7: w_seg = 8'hF8;
            4'h8: w_seg = 8'h80;  4'h9: w_seg = 8'h90;
            4'hA: w_seg = 8'h88;  4'hB: w_seg = 8'h83;
            4'hC: w_seg = 8'hC6;  4'hD: w_seg = 8'hA1;
            4'hE: w_seg = 8'h86;  4'hF: w_seg = 8'h8E;
            default: w_seg = 8'hC0;
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge w_rst) begin
        if (w_rst) begin
            r_scan <= '0;
            r_seg  <= 8'hC0;
            r_an   <= 4'b1110;
        end else begin
            r_scan <= r_scan + 1'b1;
            r_seg  <= w_seg;
            r_an   <= ~(4'b0001 << w_digit);
        end
    end

    assign SEGMENT = r_seg;
    assign AN_SEL  = r_an;

    // ---------------- VGA 640x480 ----------------
    logic [PIX_W-1:0] r_pix;
    logic [9:0]       r_h, r_v;
    logic             w_tick;
    logic             r_hs, r_vs;
    logic [7:0]       r_rgb;

    assign w_tick = (r_pix == PIX_LAST);

    always_ff @(posedge clk_100mhz or posedge w_rst) begin
        if (w_rst) begin
            r_pix <= '0;
            r_h   <= 10'd0;
            r_v   <= 10'd0;
        end else begin
            r_pix <= w_tick ? '0 : r_pix + 1'b1;
            if (w_tick) begin
                if (r_h == 10'd799) begin
                    r_h <= 10'd0;
                    r_v <= (r_v == 10'd524) ? 10'd0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_100mhz or posedge w_rst) begin
        if (w_rst) begin
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_rgb <= 8'h00;
        end else begin
            r_hs  <= !((r_h >= 10'd656) && (r_h <= 10'd751));
            r_vs  <= !((r_v == 10'd490) || (r_v == 10'd491));
            r_rgb <= ((r_h < 10'd640) && (r_v < 10'd480)) ? SW : 8'h00;
        end
    end

    assign HSYNC = r_hs;
    assign VSYNC = r_vs;
    assign Red   = r_rgb[7:5];
    assign Green = r_rgb[4:2];
    assign Blue  = r_rgb[1:0];
endmodule

// File: tb/tb_top_n3_computer_iobus_vga_ps2.sv
// Bench for the N3 I/O top: PS/2 frames against a byte-history model,
// 7-segment digit readout, and VGA sync/colour against a pixel-position model.
module tb_top_n3_computer_iobus_vga_ps2;
    localparam int SCAN_BITS   = 6;
    localparam int PIX_DIV     = 2;
    localparam int PS2_TIMEOUT = 100;

    logic       clk = 1'b0;
    logic [4:0] BTN = 5'b01000;
    logic [7:0] SW = 8'h00;
    logic       PS2_clk = 1'b1;
    logic       PS2_Data = 1'b1;
    logic [7:0] LED, SEGMENT;
    logic [3:0] AN_SEL;
    logic [2:0] Red, Green;
    logic [1:0] Blue;
    logic       HSYNC, VSYNC;

    int tot = 0;
    int bad = 0;
    int cyc = 0;

    logic [31:0] m_hist = 32'h0;
    logic [7:0]  m_led = 8'h00;
    logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    top_n3_computer_iobus_vga_ps2 #(
        .SCAN_BITS(SCAN_BITS), .PIX_DIV(PIX_DIV), .PS2_TIMEOUT(PS2_TIMEOUT)
    ) dut (
        .clk_100mhz(clk), .BTN(BTN), .SW(SW), .PS2_clk(PS2_clk), .PS2_Data(PS2_Data),
        .LED(LED), .SEGMENT(SEGMENT), .AN_SEL(AN_SEL), .Red(Red), .Green(Green),
        .Blue(Blue), .HSYNC(HSYNC), .VSYNC(VSYNC)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release drive the VGA position model.
    always @(posedge clk or posedge BTN[3]) begin
        if (BTN[3]) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic ps2_bit(input logic d);
        PS2_Data = d;
        repeat (5) @(negedge clk);
        PS2_clk = 1'b0;
        repeat (5) @(negedge clk);
        PS2_clk = 1'b1;
    endtask

    // Full 11-bit frame; checks LED is not early (before 3 clocks) and
    // has landed by 4 clocks after the final falling edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input string nm);
        logic [7:0] old_led;
        logic [7:0] exp_led;
        old_led = m_led;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(1'($urandom_range(0, 1)));
        PS2_Data = stop;
        repeat (5) @(negedge clk);
        PS2_clk = 1'b0;
        if (stop && !BTN[0]) begin
            m_hist = {m_hist[23:0], b};
            m_led  = b;
        end
        exp_led = m_led;
        repeat (2) @(negedge clk);
        if (exp_led != old_led) begin
            tot++;
            if (LED !== old_led) begin
                bad++;
                $display("FAIL %s_early: LED=%h want %h", nm, LED, old_led);
            end
        end
        repeat (2) @(negedge clk);
        tot++;
        if (LED !== exp_led) begin
            bad++;
            $display("FAIL %s_led: LED=%h want %h", nm, LED, exp_led);
        end
        repeat (1) @(negedge clk);
        PS2_clk = 1'b1;
        PS2_Data = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic check_display(input logic sw0, input string nm);
        logic [15:0] word;
        logic [3:0]  nib;
        logic [3:0]  an;
        bit          found;
        SW[0] = sw0;
        repeat (2) @(negedge clk);
        word = sw0 ? m_hist[31:16] : m_hist[15:0];
        for (int k = 0; k < 4; k++) begin
            nib   = 4'((word >> (4 * k)) & 16'hF);
            an    = ~(4'b0001 << k);
            found = 0;
            for (int c = 0; c < (1 << SCAN_BITS) + 4 && !found; c++) begin
                @(negedge clk);
                if (AN_SEL === an) begin
                    found = 1;
                    tot++;
                    if (SEGMENT !== hex_tab[nib]) begin
                        bad++;
                        $display("FAIL %s_dig%0d: SEGMENT=%h want %h", nm, k, SEGMENT, hex_tab[nib]);
                    end
                end
            end
            if (!found) begin
                tot++;
                bad++;
                $display("FAIL %s_scan%0d: AN_SEL never %b", nm, k, an);
            end
        end
    endtask

    task automatic test_reset();
        BTN = 5'b01000;
        repeat (10) @(negedge clk);
        tot++;
        if ({LED, AN_SEL, SEGMENT, HSYNC, VSYNC, Red, Green, Blue} !==
            {8'h00, 4'b1110, 8'hC0, 1'b1, 1'b1, 8'h00}) begin
            bad++;
            $display("FAIL reset: LED=%h AN=%b SEG=%h HS=%b VS=%b RGB=%h want 00 1110 C0 1 1 00",
                     LED, AN_SEL, SEGMENT, HSYNC, VSYNC, {Red, Green, Blue});
        end
        BTN = 5'b00000;
        m_hist = 32'h0;
        m_led  = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_first_frame();
        send_frame(8'h5A, 1'b1, "frame5A");
        check_display(1'b0, "disp5A");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) send_frame(8'h5A, 1'b1, "b2b");
        tot++;
        if (m_hist !== 32'h5A5A5A5A) begin
            bad++;
            $display("FAIL b2b_model: hist=%h want 5a5a5a5a", m_hist);
        end
        check_display(1'b1, "b2b_hi");
        check_display(1'b0, "b2b_lo");
    endtask

    task automatic test_bad_stop();
        send_frame(8'h77, 1'b0, "badstop");
        check_display(1'b0, "badstop");
        send_frame(8'h0D, 1'b1, "after_bad");
    endtask

    task automatic test_timeout();
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        repeat (PS2_TIMEOUT + 1) @(negedge clk);
        send_frame(8'h1C, 1'b1, "timeout");
        check_display(1'b0, "timeout");
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       st;
        for (int n = 0; n < 8; n++) begin
            b  = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            send_frame(b, st, "rand");
            check_display(1'($urandom_range(0, 1)), "rand_disp");
        end
    endtask

    task automatic test_clear();
        BTN[0] = 1'b1;
        m_hist = 32'h0;
        m_led  = 8'h00;
        send_frame(8'($urandom), 1'b1, "clear_hold");
        BTN[0] = 1'b0;
        check_display(1'b0, "clear_lo");
        check_display(1'b1, "clear_hi");
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 5; i++) ps2_bit(1'b0);
        BTN[3] = 1'b1;
        repeat (3) @(negedge clk);
        BTN[3] = 1'b0;
        m_hist = 32'h0;
        m_led  = 8'h00;
        tot++;
        if (LED !== 8'h00) begin
            bad++;
            $display("FAIL midreset_led: LED=%h want 00", LED);
        end
        send_frame(8'h3C, 1'b1, "midreset");
        check_display(1'b0, "midreset");
    endtask

    task automatic test_vga();
        int t, h, v, lows, guard;
        logic exp_hs, exp_vs;
        logic [7:0] exp_rgb;
        SW = 8'hFF;
        guard = 0;
        // Align to the first clock of a line so sync-width counts are per line.
        do begin
            @(negedge clk);
            guard++;
        end while (!(cyc >= 1 && ((cyc - 1) % PIX_DIV) == 0 && (((cyc - 1) / PIX_DIV) % 800) == 0)
                   && guard < 3000);
        if (guard >= 3000) begin
            tot++;
            bad++;
            $display("FAIL vga_align: no line start within %0d clocks", guard);
        end
        for (int line = 0; line < 3; line++) begin
            lows = 0;
            for (int c = 0; c < 800 * PIX_DIV; c++) begin
                if (c != 0) @(negedge clk);
                t = (cyc - 1) / PIX_DIV;
                h = t % 800;
                v = (t / 800) % 525;
                exp_hs  = !(h >= 656 && h <= 751);
                exp_vs  = !(v == 490 || v == 491);
                exp_rgb = (h < 640 && v < 480) ? SW : 8'h00;
                if (!HSYNC) lows++;
                tot++;
                if ({HSYNC, VSYNC, Red, Green, Blue} !== {exp_hs, exp_vs, exp_rgb}) begin
                    bad++;
                    $display("FAIL vga_px h=%0d v=%0d: HS=%b VS=%b RGB=%h want %b %b %h",
                             h, v, HSYNC, VSYNC, {Red, Green, Blue}, exp_hs, exp_vs, exp_rgb);
                end
            end
            tot++;
            if (lows != 96 * PIX_DIV) begin
                bad++;
                $display("FAIL vga_hs_width line %0d: low clocks=%0d want %0d", line, lows, 96 * PIX_DIV);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_bad_stop();
        test_timeout();
        test_random();
        test_clear();
        test_reset_midframe();
        test_vga();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
